btb_trainer: RTL and testbench

Branch-resolution side of the BTB: takes the two resolved-branch slots from EX, detects mispredictions, issues a registered frontend redirect, and queues BTB training records. A small FIFO drains one record per accepted cycle onto the BTB update port (`branch_mistaken`, `ins_type_w`, `wrong_pc`, `right_target`). It sits between the EX branch units and the BTB/IF stage.

---
 rtl/btb_trainer_pkg.sv | 17 +
 rtl/btb_train_fifo.sv | 83 ++++++++
 rtl/btb_trainer.sv | 92 +++++++++
 tb/tb_btb_trainer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/btb_trainer_pkg.sv
// rtl/btb_trainer_pkg.sv - shared predictor types: instruction-type encoding and BTB training record
package btb_trainer_pkg;

  localparam logic [2:0] INS_NONE   = 3'd0;
  localparam logic [2:0] INS_BRANCH = 3'd1;
  localparam logic [2:0] INS_JUMP   = 3'd2;
  localparam logic [2:0] INS_CALL   = 3'd3;
  localparam logic [2:0] INS_RET    = 3'd4;
  localparam logic [2:0] INS_JR     = 3'd5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [2:0]  ins_type;
  } btb_train_t;

endpackage

// File: rtl/btb_train_fifo.sv
// rtl/btb_train_fifo.sv - training record FIFO feeding the BTB update port
// Optional same-pc merge CAM under BTB_TRAIN_MERGE_EN.
module btb_train_fifo
  import btb_trainer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enq_valid,
  input  btb_train_t enq_data,
  input  logic       upd_ready,
  output logic       upd_valid,
  output btb_train_t head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  btb_train_t     mem [DEPTH];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [CW-1:0]  count;
  logic           deq;
  logic           enq_acc;
  logic           merge_hit;

  assign upd_valid = (count != '0);
  assign head_data = mem[head];
  assign deq       = upd_valid & upd_ready;

`ifdef BTB_TRAIN_MERGE_EN
  logic [AW-1:0] merge_idx;
  logic [AW-1:0] idx;
  logic [AW-1:0] off;

  // An occupied entry sits within count slots of head; a head leaving this cycle cannot absorb a merge.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    idx       = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = AW'(i);
      off = idx - head;
      if (enq_valid && ({1'b0, off} < count) && (mem[idx].pc == enq_data.pc) &&
          !(deq && (idx == head))) begin
        merge_hit = 1'b1;
        merge_idx = idx;
      end
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign enq_acc = enq_valid & ~merge_hit & ((count < CW'(DEPTH)) | deq);

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq)     head <= head + 1'b1;
      if (enq_acc) tail <= tail + 1'b1;
      count <= count + CW'(enq_acc) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_acc) begin
      mem[tail] <= enq_data;
    end
`ifdef BTB_TRAIN_MERGE_EN
    else if (merge_hit) begin
      mem[merge_idx].target   <= enq_data.target;
      mem[merge_idx].ins_type <= enq_data.ins_type;
    end
`endif
  end

endmodule

// File: rtl/btb_trainer.sv
// rtl/btb_trainer.sv - EX branch resolution: mispredict detect, registered redirect, BTB training queue
// BTB_TRAIN_MERGE_EN enables same-pc merging in the training FIFO.
module btb_trainer
  import btb_trainer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        br_valid_0,
  input  logic [31:0] br_pc_0,
  input  logic [2:0]  br_type_0,
  input  logic        pred_taken_0,
  input  logic [31:0] pred_target_0,
  input  logic        act_taken_0,
  input  logic [31:0] act_target_0,
  input  logic        br_valid_1,
  input  logic [31:0] br_pc_1,
  input  logic [2:0]  br_type_1,
  input  logic        pred_taken_1,
  input  logic [31:0] pred_target_1,
  input  logic        act_taken_1,
  input  logic [31:0] act_target_1,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic [2:0]  upd_type
);

  logic        mp_0;
  logic        mp_1;
  logic        sel_valid;
  logic        sel_taken;
  logic [31:0] sel_pc;
  logic [31:0] sel_target;
  logic [2:0]  sel_type;
  logic [31:0] redirect_next;
  btb_train_t  enq_data;
  btb_train_t  head_data;

  assign mp_0 = br_valid_0 & ~flush &
                ((pred_taken_0 != act_taken_0) | (act_taken_0 & (pred_target_0 != act_target_0)));
  // A slot-0 mispredict makes slot 1 wrong-path.
  assign mp_1 = ~mp_0 & br_valid_1 & ~flush &
                ((pred_taken_1 != act_taken_1) | (act_taken_1 & (pred_target_1 != act_target_1)));

  always_comb begin
    sel_taken  = act_taken_0;
    sel_pc     = br_pc_0;
    sel_target = act_target_0;
    sel_type   = br_type_0;
    if (!mp_0) begin
      sel_taken  = act_taken_1;
      sel_pc     = br_pc_1;
      sel_target = act_target_1;
      sel_type   = br_type_1;
    end
  end

  assign sel_valid     = mp_0 | mp_1;
  assign redirect_next = sel_taken ? sel_target : (sel_pc + 32'd4);
  assign enq_data      = '{pc: sel_pc, target: sel_target, ins_type: sel_type};

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= sel_valid;
      if (sel_valid) redirect_pc <= redirect_next;
    end
  end

  btb_train_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (sel_valid & sel_taken),
    .enq_data  (enq_data),
    .upd_ready (upd_ready),
    .upd_valid (upd_valid),
    .head_data (head_data)
  );

  assign upd_pc     = head_data.pc;
  assign upd_target = head_data.target;
  assign upd_type   = head_data.ins_type;

endmodule

// File: tb/tb_btb_trainer.sv
// tb/tb_btb_trainer.sv - directed bench for btb_trainer with DEPTH=4
module tb_btb_trainer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        br_valid_0, br_valid_1;
  logic [31:0] br_pc_0, br_pc_1;
  logic [2:0]  br_type_0, br_type_1;
  logic        pred_taken_0, pred_taken_1;
  logic [31:0] pred_target_0, pred_target_1;
  logic        act_taken_0, act_taken_1;
  logic [31:0] act_target_0, act_target_1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [2:0]  upd_type;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_trainer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .br_valid_0(br_valid_0), .br_pc_0(br_pc_0), .br_type_0(br_type_0),
    .pred_taken_0(pred_taken_0), .pred_target_0(pred_target_0),
    .act_taken_0(act_taken_0), .act_target_0(act_target_0),
    .br_valid_1(br_valid_1), .br_pc_1(br_pc_1), .br_type_1(br_type_1),
    .pred_taken_1(pred_taken_1), .pred_target_1(pred_target_1),
    .act_taken_1(act_taken_1), .act_target_1(act_target_1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_type(upd_type)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slots();
    br_valid_0 = 0; br_pc_0 = '0; br_type_0 = '0; pred_taken_0 = 0; pred_target_0 = '0;
    act_taken_0 = 0; act_target_0 = '0;
    br_valid_1 = 0; br_pc_1 = '0; br_type_1 = '0; pred_taken_1 = 0; pred_target_1 = '0;
    act_taken_1 = 0; act_target_1 = '0;
  endtask

  task automatic drv0(input logic [31:0] pc, input logic [2:0] ty, input logic pt,
                      input logic [31:0] ptgt, input logic at, input logic [31:0] atgt);
    br_valid_0 = 1; br_pc_0 = pc; br_type_0 = ty; pred_taken_0 = pt;
    pred_target_0 = ptgt; act_taken_0 = at; act_target_0 = atgt;
  endtask

  task automatic drv1(input logic [31:0] pc, input logic [2:0] ty, input logic pt,
                      input logic [31:0] ptgt, input logic at, input logic [31:0] atgt);
    br_valid_1 = 1; br_pc_1 = pc; br_type_1 = ty; pred_taken_1 = pt;
    pred_target_1 = ptgt; act_taken_1 = at; act_target_1 = atgt;
  endtask

  initial begin
    reset = 1; flush = 0; upd_ready = 0;
    clear_slots();
    tick(); tick();
    reset = 0;
    chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_upd_valid", {31'd0, upd_valid}, 32'd0);

    // Basic taken mispredict
    drv0(32'h1c000100, 3'd1, 0, 32'h0, 1, 32'h1c000200);
    tick();
    chk("t1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t1_redirect_pc", redirect_pc, 32'h1c000200);
    chk("t1_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t1_upd_pc", upd_pc, 32'h1c000100);
    chk("t1_upd_target", upd_target, 32'h1c000200);
    chk("t1_upd_type", {29'd0, upd_type}, 32'd1);
    clear_slots(); upd_ready = 1;
    tick();
    chk("t1_redirect_pulse", {31'd0, redirect_valid}, 32'd0);
    chk("t1_drained", {31'd0, upd_valid}, 32'd0);

    // Both slots mispredict: slot 1 is wrong-path
    upd_ready = 0;
    drv0(32'h00001000, 3'd2, 0, 32'h0, 1, 32'h00002000);
    drv1(32'h00001004, 3'd3, 0, 32'h0, 1, 32'h00003000);
    tick();
    chk("t2_redirect_pc", redirect_pc, 32'h00002000);
    chk("t2_upd_pc", upd_pc, 32'h00001000);
    chk("t2_upd_type", {29'd0, upd_type}, 32'd2);
    clear_slots();
    tick();
    chk("t2_head_stable", upd_pc, 32'h00001000);
    upd_ready = 1;
    tick();
    chk("t2_slot1_not_queued", {31'd0, upd_valid}, 32'd0);

    // Slot 0 correct, slot 1 taken with wrong target
    drv0(32'h00004000, 3'd1, 1, 32'h00004100, 1, 32'h00004100);
    drv1(32'h00004004, 3'd5, 1, 32'h00005000, 1, 32'h00005008);
    upd_ready = 0;
    tick();
    chk("t2b_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t2b_redirect_pc", redirect_pc, 32'h00005008);
    chk("t2b_upd_pc", upd_pc, 32'h00004004);
    chk("t2b_upd_type", {29'd0, upd_type}, 32'd5);
    clear_slots(); upd_ready = 1;
    tick();

    // Not-taken mispredict at top of address space: wraps, no training
    drv0(32'hfffffffc, 3'd1, 1, 32'h00000040, 0, 32'h0);
    tick();
    chk("t3_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t3_redirect_pc_wrap", redirect_pc, 32'h00000000);
    chk("t3_no_enqueue", {31'd0, upd_valid}, 32'd0);
    // Correct prediction: no redirect
    drv0(32'h00006000, 3'd1, 1, 32'h00006100, 1, 32'h00006100);
    tick();
    chk("t3_correct_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("t3_correct_no_enqueue", {31'd0, upd_valid}, 32'd0);

    // Five records into a stalled DEPTH=4 queue; fifth is dropped
    upd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drv0(32'h00000100 + 32'(i * 16), 3'd1, 0, 32'h0, 1, 32'h00002000 + 32'(i));
      tick();
    end
    clear_slots();
    chk("t4_head0", upd_pc, 32'h00000100);
    upd_ready = 1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t4_drain_pc", upd_pc, 32'h00000100 + 32'(i * 16));
      chk("t4_drain_target", upd_target, 32'h00002000 + 32'(i));
    end
    tick();
    chk("t4_fifth_dropped", {31'd0, upd_valid}, 32'd0);

    // Full queue with simultaneous dequeue accepts the new record
    upd_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drv0(32'h00000b00 + 32'(i * 4), 3'd1, 0, 32'h0, 1, 32'h0000c000 + 32'(i));
      tick();
    end
    upd_ready = 1;
    drv0(32'h00000b10, 3'd1, 0, 32'h0, 1, 32'h0000c004);
    tick();
    clear_slots();
    chk("t5_head_after_deq", upd_pc, 32'h00000b04);
    tick();
    chk("t5_b2", upd_pc, 32'h00000b08);
    tick();
    chk("t5_b3", upd_pc, 32'h00000b0c);
    tick();
    chk("t5_new_accepted", upd_pc, 32'h00000b10);
    chk("t5_new_target", upd_target, 32'h0000c004);
    tick();
    chk("t5_empty", {31'd0, upd_valid}, 32'd0);

    // Flush kills the EX slot but leaves queued records
    upd_ready = 0;
    drv0(32'h00000c00, 3'd1, 0, 32'h0, 1, 32'h00000d00);
    tick();
    flush = 1;
    drv0(32'h00000e00, 3'd1, 0, 32'h0, 1, 32'h00000f00);
    tick();
    flush = 0;
    clear_slots();
    chk("t6_flush_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("t6_flush_queue_kept", upd_pc, 32'h00000c00);
    upd_ready = 1;
    tick();
    chk("t6_flush_no_enqueue", {31'd0, upd_valid}, 32'd0);

    // Two records for the same pc while stalled
    upd_ready = 0;
    drv0(32'h1c000100, 3'd1, 0, 32'h0, 1, 32'h0000aaaa);
    tick();
    drv0(32'h1c000100, 3'd2, 0, 32'h0, 1, 32'h0000bbbb);
    tick();
    clear_slots();
`ifdef BTB_TRAIN_MERGE_EN
    chk("t7_merged_target", upd_target, 32'h0000bbbb);
    chk("t7_merged_type", {29'd0, upd_type}, 32'd2);
    upd_ready = 1;
    tick();
    chk("t7_merged_count1", {31'd0, upd_valid}, 32'd0);
`else
    chk("t7_dup_first", upd_target, 32'h0000aaaa);
    upd_ready = 1;
    tick();
    chk("t7_dup_second", upd_target, 32'h0000bbbb);
    tick();
    chk("t7_dup_empty", {31'd0, upd_valid}, 32'd0);
`endif

    // Mid-operation reset empties the queue
    upd_ready = 0;
    drv0(32'h00007000, 3'd1, 0, 32'h0, 1, 32'h00007100);
    tick();
    clear_slots();
    chk("t8_pre_reset_valid", {31'd0, upd_valid}, 32'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("t8_reset_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("t8_reset_redirect", {31'd0, redirect_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
